aes_decrypt_top: RTL and testbench
==================================

Name: aes_decrypt_top

Overview:
Iterative AES-128 decryption core, the inverse counterpart of the team's AES-128 encryption core, sharing the same start/ready interface style.
- Accepts a 128-bit ciphertext block and the original cipher key (not the last round key).
- Runs the forward key schedule internally to reach round key 10, then runs the inverse cipher while regenerating earlier round keys on the fly.
- Produces plaintext with a level `ready` flag.

Parameters:
none

Ports:
- CLK  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request a decryption; sampled only in IDLE
- in  input  128  ciphertext; byte 0 = in[127:120], column-major (FIPS-197 ordering)
- key  input  128  AES-128 cipher key, same byte ordering
- out  output  128  plaintext; registered; holds its value until the next result or reset
- ready  output  1  high when `out` holds a valid result
- busy  output  1  high from the cycle after start acceptance until the FINAL edge

Behaviour:
- Reset (asynchronous, active-high): FSM=IDLE, out=0, ready=0, busy=0, internal state/round key/round counter/rcon cleared. Reset mid-operation aborts with no output update.
- FSM states: IDLE -> KEXP -> INIT -> ROUND -> FINAL -> IDLE.
- IDLE, start=1 (edge E0):
  - capture `in` into the state register and `key` into the round-key register;
  - rcon=0x01, cnt=0, ready<=0, busy<=1.
  - start=0 in IDLE: no change.
  - start while ready=1 is accepted; ready clears at that edge.
- KEXP (edges E1..E10): each edge applies one forward key-expansion step.
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - rcon <= xtime(rcon); 0x80 -> 0x1B (0x1B then 0x36).
  - After E10 the register holds rk10 and rcon holds 0x6C (unused); set rcon=0x36 for the reverse walk.
- INIT (E11): state <= state ^ rk10; round key <= rk9 (inverse step, below); rcon <= inverse-xtime(rcon).
- Inverse key step from rk_r to rk_(r-1), using that round's rcon:
  - w3'=w3^w2; w2'=w2^w1; w1'=w1^w0;
  - w0'=w0 ^ SubWord(RotWord(w3')) ^ {rcon,24'h0}.
  - Rcon sequence walked: 0x36,0x1B,0x80,0x40,...,0x01.
- ROUND (E12..E20, 9 edges, rounds 9 down to 1): each edge applies, combinationally,
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_r), and
  - round key <= rk_(r-1).
  - The counter selects FINAL after the 9th ROUND edge.
- FINAL (E21):
  - out <= InvSubBytes(InvShiftRows(state)) ^ rk0;
  - ready<=1, busy<=0, FSM=IDLE.
- Latency: `out` and `ready` are valid after edge E21, i.e. 21 cycles after the accepting edge.
- Throughput: one block per 22 cycles minimum, when start is held high.
- InvShiftRows: row r rotates right by r bytes. State byte (row i, col c) = in[127-8*(4c+i) -: 8].
- InvMixColumns matrix rows are {0e,0b,0d,09} rotated; GF(2^8) polynomial 0x11B.
- Inverse S-box is a separate leaf module `inv_sbox` (8-bit B -> D), 16 instances. The key schedule reuses the existing forward SBox leaf (4 instances).
- `in`, `key` and `start` changes while busy are ignored. `out` is stable from E21 until the FINAL of the next operation.

Test Plan:
1. FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, in=69c4e0d86a7b0430d8cdb78070b4c55a, start 1 cycle -> after 21 edges out=00112233445566778899aabbccddeeff, ready=1, busy=0.
2. FIPS-197 App B: key=2b7e151628aed2a6abf7158809cf4f3c, in=3925841d02dc09fbdc118597196a0b32 -> out=3243f6a8885a308d313198a2e0370734. Additionally, toggle `in`/`key` randomly while busy; the result is unchanged.
3. Zero key, in=66e94bd4ef8a2c3b884cfa59ca342b2e -> out=0. Back-to-back: start held high, case 1 then case 2 -> ready drops at second accept, second result 22 cycles after the first.
4. Reset asserted at E8 of case 1 -> out=0, ready=0, busy=0 immediately; a subsequent start of case 2 completes correctly.
5. Round-trip: 1000 random key/plaintext pairs through the AES encryption core, then this block -> out equals original plaintext; ready asserted exactly 21 edges after each accept.
6. start=1 pulses during busy (E5, E15) -> ignored; exactly one ready rise, result still correct.

Source files
------------

// File: rtl/aes_decrypt_top_if.sv
// Request/result bundle for the iterative AES-128 decryption core.
// The requester drives start/in/key; the core returns out/ready/busy.
interface aes_decrypt_top_if;
    logic         start;
    logic [127:0] in;
    logic [127:0] key;
    logic [127:0] out;
    logic         ready;
    logic         busy;

    modport master (
        output start, in, key,
        input  out, ready, busy
    );

    modport slave (
        input  start, in, key,
        output out, ready, busy
    );
endinterface

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 decryption: forward key walk to rk10, then the
// inverse cipher with round keys regenerated backwards on the fly.
package aes_decrypt_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] a);
        return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the field inverse, with 0 mapping to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] y;
        y = a;
        for (int i = 0; i < 6; i++) y = gf_mul(gf_mul(y, y), a);
        return gf_mul(y, y);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a,
                                         input int n);
        return (a << n) | (a >> (8 - n));
    endfunction
endpackage

module sbox
    import aes_decrypt_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] v;
    assign v = gf_inv(a);
    assign y = v ^ rotl8(v, 1) ^ rotl8(v, 2)
             ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
endmodule

module inv_sbox
    import aes_decrypt_pkg::*;
(
    input  logic [7:0] b,
    output logic [7:0] d
);
    logic [7:0] u;
    assign u = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    assign d = gf_inv(u);
endmodule

module aes_decrypt_top
    import aes_decrypt_pkg::*;
(
    input  logic          CLK,
    input  logic          reset,
    aes_decrypt_top_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, KEXP, INIT, ROUND, FINAL
    } state_t;

    state_t       fsm;
    logic [127:0] st;
    logic [127:0] rk;
    logic [7:0]   rcon;
    logic [3:0]   cnt;
    logic [127:0] out_q;
    logic         ready_q;
    logic         busy_q;

    assign bus.out   = out_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;

    logic [127:0] isr;
    logic [127:0] isb;
    logic [127:0] ark;
    logic [127:0] imc;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int N = 4 * c + r;
            localparam int S = 4 * ((c - r + 4) % 4) + r;
            assign isr[127-8*N -: 8] = st[127-8*S -: 8];
            inv_sbox u_isb (
                .b (isr[127-8*N -: 8]),
                .d (isb[127-8*N -: 8])
            );
        end
    end

    assign ark = isb ^ rk;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[127-32*c -: 8];
        assign a1 = ark[119-32*c -: 8];
        assign a2 = ark[111-32*c -: 8];
        assign a3 = ark[103-32*c -: 8];
        assign imc[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                  ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign imc[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                  ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign imc[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                  ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign imc[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                  ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] i3, sin, sw, t0;
    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;

    assign {w0, w1, w2, w3} = rk;
    assign i3 = w3 ^ w2;

    // One SubWord serves both directions; only its input differs
    assign sin = (fsm == KEXP) ? {w3[23:0], w3[31:24]}
                               : {i3[23:0], i3[31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_ks
        sbox u_sb (
            .a (sin[31-8*k -: 8]),
            .y (sw[31-8*k -: 8])
        );
    end

    assign t0 = w0 ^ sw ^ {rcon, 24'h0};
    assign rk_fwd = {t0, w1 ^ t0, w2 ^ w1 ^ t0, w3 ^ w2 ^ w1 ^ t0};
    assign rk_inv = {t0, w1 ^ w0, w2 ^ w1, i3};

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fsm     <= IDLE;
            st      <= '0;
            rk      <= '0;
            rcon    <= '0;
            cnt     <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (bus.start) begin
                        st      <= bus.in;
                        rk      <= bus.key;
                        rcon    <= 8'h01;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        fsm     <= KEXP;
                    end
                end
                KEXP: begin
                    rk <= rk_fwd;
                    if (cnt == 4'd9) begin
                        rcon <= 8'h36;
                        cnt  <= '0;
                        fsm  <= INIT;
                    end else begin
                        rcon <= xtime(rcon);
                        cnt  <= cnt + 4'd1;
                    end
                end
                INIT: begin
                    st   <= st ^ rk;
                    rk   <= rk_inv;
                    rcon <= inv_xtime(rcon);
                    fsm  <= ROUND;
                end
                ROUND: begin
                    st   <= imc;
                    rk   <= rk_inv;
                    rcon <= inv_xtime(rcon);
                    if (cnt == 4'd8) begin
                        cnt <= '0;
                        fsm <= FINAL;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                FINAL: begin
                    out_q   <= ark;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    fsm     <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt_top.sv
// Directed bench for aes_decrypt_top: known-answer vectors, latency,
// back-to-back starts, mid-run reset and ignored inputs while busy.
module tb_aes_decrypt_top;
    logic CLK;
    logic reset;
    int   checks;
    int   failures;

    aes_decrypt_top_if bus ();

    aes_decrypt_top dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One accept (E0) followed by exactly 21 edges to the result
    task automatic run_op(input logic [127:0] ct, input logic [127:0] k,
                          input logic [127:0] exp, input string tag,
                          input bit scramble, input bit pulses);
        bus.start = 1'b1;
        bus.in    = ct;
        bus.key   = k;
        cyc();
        bus.start = 1'b0;
        chk({tag, "_busy_e0"}, bus.busy, 1);
        chk({tag, "_ready_e0"}, bus.ready, 0);
        for (int e = 1; e <= 20; e++) begin
            if (scramble) begin
                bus.in  = rnd128();
                bus.key = rnd128();
            end
            bus.start = pulses && (e == 5 || e == 15);
            cyc();
        end
        bus.start = 1'b0;
        chk({tag, "_ready_e20"}, bus.ready, 0);
        chk({tag, "_busy_e20"}, bus.busy, 1);
        cyc();
        chk({tag, "_out"}, bus.out, exp);
        chk({tag, "_ready"}, bus.ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in    = '0;
        bus.key   = '0;
        cyc();
        cyc();
        chk("rst_out", bus.out, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        cyc();

        run_op(C1, K1, P1, "c1", 1'b0, 1'b0);
        cyc();
        chk("c1_hold_out", bus.out, P1);
        chk("c1_hold_ready", bus.ready, 1);

        run_op(C2, K2, P2, "app_b_scramble", 1'b1, 1'b0);
        run_op(C0, '0, '0, "zero_key", 1'b0, 1'b0);

        // start held high across two operations
        bus.start = 1'b1;
        bus.in    = C1;
        bus.key   = K1;
        cyc();
        for (int e = 1; e <= 20; e++) cyc();
        bus.in  = C2;
        bus.key = K2;
        cyc();
        chk("b2b_first_out", bus.out, P1);
        chk("b2b_first_ready", bus.ready, 1);
        cyc();
        chk("b2b_accept_ready", bus.ready, 0);
        chk("b2b_accept_busy", bus.busy, 1);
        bus.start = 1'b0;
        for (int e = 1; e <= 20; e++) cyc();
        chk("b2b_ready_e42", bus.ready, 0);
        cyc();
        chk("b2b_second_out", bus.out, P2);
        chk("b2b_second_ready", bus.ready, 1);

        // abort just before E8
        bus.start = 1'b1;
        bus.in    = C1;
        bus.key   = K1;
        cyc();
        bus.start = 1'b0;
        for (int e = 1; e <= 7; e++) cyc();
        reset = 1'b1;
        #1;
        chk("abort_out", bus.out, 0);
        chk("abort_ready", bus.ready, 0);
        chk("abort_busy", bus.busy, 0);
        cyc();
        reset = 1'b0;
        cyc();
        run_op(C2, K2, P2, "after_abort", 1'b0, 1'b0);

        run_op(C1, K1, P1, "pulses", 1'b0, 1'b1);
        cyc();
        cyc();
        chk("pulses_ready_held", bus.ready, 1);
        chk("pulses_busy_idle", bus.busy, 0);
        chk("pulses_out_held", bus.out, P1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
